// File: rtl/pixel_ctrl_pkg.sv
// Shared types and default sizing for the pixel frame controller and its bench.
// Optional test-pattern feature is controlled by PIXEL_TEST_PATTERN_EN (see pixel_frame_ctrl).
package pixel_ctrl_pkg;

  localparam int DEF_N_PIXELS  = 4;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_C_ERASE   = 5;
  localparam int DEF_C_EXPOSE  = 255;
  localparam int DEF_C_CONVERT = 255;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ERASE   = 3'd1,
    S_EXPOSE  = 3'd2,
    S_CONVERT = 3'd3,
    S_RD_SEL  = 3'd4,
    S_RD_CAP  = 3'd5,
    S_RD_WAIT = 3'd6,
    S_DONE    = 3'd7
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pixel_frame_ctrl_phase_timer.sv
// Loadable down-counter shared by the erase, expose and convert phases.
// done is high while the count sits at zero, i.e. in the last cycle of a phase.
module phase_timer #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_r;

  // Count down to zero after each load and park there.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= '0;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (cnt_r != '0) begin
      cnt_r <= cnt_r - W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign done = (cnt_r == '0);

endmodule

// File: rtl/pixel_frame_ctrl.sv
// Frame sequencer for the shared-bus pixel array: erase, expose, convert, then read out.
// Define PIXEL_TEST_PATTERN_EN to add test_mode, which replaces pixel data with frame_cnt + idx.
module pixel_frame_ctrl
  import pixel_ctrl_pkg::*;
#(
  parameter int N_PIXELS  = DEF_N_PIXELS,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int C_ERASE   = DEF_C_ERASE,
  parameter int C_EXPOSE  = DEF_C_EXPOSE,
  parameter int C_CONVERT = DEF_C_CONVERT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
`ifdef PIXEL_TEST_PATTERN_EN
  input  logic                test_mode,
`endif
  output logic                busy,
  output logic                erase,
  output logic                expose,
  output logic                convert,
  output logic [DATA_W-1:0]   ramp_cnt,
  output logic                bus_oe,
  output logic [N_PIXELS-1:0] read_en,
  input  logic [DATA_W-1:0]   pix_bus,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last,
  output logic                frame_done
);

  localparam int CNT_W = $clog2(max3(C_ERASE, C_EXPOSE, C_CONVERT) + 1);
  localparam int IDX_W = (N_PIXELS > 1) ? $clog2(N_PIXELS) : 1;
  localparam logic [DATA_W-1:0] RAMP_MAX = '1;
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(N_PIXELS - 1);

  state_t              state_r, state_s;
  logic [IDX_W-1:0]    idx_r, idx_s;
  logic                timer_load_s, timer_done_s, rd_active_s;
  logic [CNT_W-1:0]    timer_val_s;
  logic [DATA_W-1:0]   ramp_s, out_data_s, capture_s;
  logic [N_PIXELS-1:0] read_en_s;
  logic                out_valid_s, out_last_s;

`ifdef PIXEL_TEST_PATTERN_EN
  logic              tm_r, tm_s;
  logic [DATA_W-1:0] frame_cnt_r;

  // Completed-frame counter feeding the test pattern; wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt_r <= '0;
    end else if (state_r == S_DONE) begin
      frame_cnt_r <= frame_cnt_r + DATA_W'(1);
    end else begin
      frame_cnt_r <= frame_cnt_r;
    end
  end

  assign capture_s = tm_r ? (frame_cnt_r + DATA_W'(idx_r)) : pix_bus;
`else
  assign capture_s = pix_bus;
`endif

  phase_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load_s),
    .load_val (timer_val_s),
    .done     (timer_done_s)
  );

  // Next state plus next value of every registered output.
  always_comb begin
    state_s      = state_r;
    idx_s        = idx_r;
    timer_load_s = 1'b0;
    timer_val_s  = '0;
    out_data_s   = out_data;
    out_valid_s  = out_valid;
    out_last_s   = out_last;
`ifdef PIXEL_TEST_PATTERN_EN
    tm_s         = tm_r;
`endif
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_s      = S_ERASE;
          idx_s        = '0;
          timer_load_s = 1'b1;
          timer_val_s  = CNT_W'(C_ERASE - 1);
`ifdef PIXEL_TEST_PATTERN_EN
          tm_s         = test_mode;
`endif
        end else begin
          state_s = S_IDLE;
        end
      end
      S_ERASE: begin
        if (timer_done_s) begin
          state_s      = S_EXPOSE;
          timer_load_s = 1'b1;
          timer_val_s  = CNT_W'(C_EXPOSE - 1);
        end else begin
          state_s = S_ERASE;
        end
      end
      S_EXPOSE: begin
        if (timer_done_s) begin
          state_s      = S_CONVERT;
          timer_load_s = 1'b1;
          timer_val_s  = CNT_W'(C_CONVERT - 1);
        end else begin
          state_s = S_EXPOSE;
        end
      end
      S_CONVERT: begin
        if (timer_done_s) begin
          state_s = S_RD_SEL;
          idx_s   = '0;
        end else begin
          state_s = S_CONVERT;
        end
      end
      S_RD_SEL: state_s = S_RD_CAP;
      S_RD_CAP: begin
        state_s     = S_RD_WAIT;
        out_data_s  = capture_s;
        out_valid_s = 1'b1;
        out_last_s  = (idx_r == IDX_LAST);
      end
      S_RD_WAIT: begin
        if (out_valid && out_ready) begin
          out_valid_s = 1'b0;
          if (idx_r != IDX_LAST) begin
            idx_s   = idx_r + IDX_W'(1);
            state_s = S_RD_SEL;
          end else begin
            state_s = S_DONE;
          end
        end else begin
          state_s = S_RD_WAIT;
        end
      end
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase

    rd_active_s = (state_s == S_RD_SEL) || (state_s == S_RD_CAP);
    read_en_s   = '0;
    if (rd_active_s) begin
      read_en_s[idx_s] = 1'b1;
    end else begin
      read_en_s = '0;
    end

    // Ramp restarts at zero on the first convert cycle and saturates at full scale.
    if ((state_s == S_CONVERT) && (state_r == S_CONVERT)) begin
      ramp_s = (ramp_cnt == RAMP_MAX) ? ramp_cnt : (ramp_cnt + DATA_W'(1));
    end else begin
      ramp_s = '0;
    end
  end

  // State and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= S_IDLE;
      idx_r      <= '0;
      busy       <= 1'b0;
      erase      <= 1'b0;
      expose     <= 1'b0;
      convert    <= 1'b0;
      ramp_cnt   <= '0;
      bus_oe     <= 1'b1;
      read_en    <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
`ifdef PIXEL_TEST_PATTERN_EN
      tm_r       <= 1'b0;
`endif
    end else begin
      state_r    <= state_s;
      idx_r      <= idx_s;
      busy       <= (state_s != S_IDLE);
      erase      <= (state_s == S_ERASE);
      expose     <= (state_s == S_EXPOSE);
      convert    <= (state_s == S_CONVERT);
      ramp_cnt   <= ramp_s;
      bus_oe     <= !rd_active_s;
      read_en    <= read_en_s;
      out_data   <= out_data_s;
      out_valid  <= out_valid_s;
      out_last   <= out_last_s;
      frame_done <= (state_s == S_DONE);
`ifdef PIXEL_TEST_PATTERN_EN
      tm_r       <= tm_s;
`endif
    end
  end

endmodule

// File: tb/tb_pixel_frame_ctrl.sv
// Self-checking bench for pixel_frame_ctrl: table-driven frames, hand-written corner sequences
// and randomized frames checked cycle by cycle against a phase/pixel-level reference model.
module tb_pixel_frame_ctrl;
  import pixel_ctrl_pkg::*;

  localparam int NP = DEF_N_PIXELS;
  localparam int DW = DEF_DATA_W;
  localparam int CE = DEF_C_ERASE;
  localparam int CX = DEF_C_EXPOSE;
  localparam int CC = DEF_C_CONVERT;

  logic          clk = 1'b0;
  logic          reset, start, out_ready;
  logic [DW-1:0] pix_bus;
  logic          busy, erase, expose, convert, bus_oe, out_valid, out_last, frame_done;
  logic [DW-1:0] ramp_cnt, out_data;
  logic [NP-1:0] read_en;
`ifdef PIXEL_TEST_PATTERN_EN
  logic          test_mode;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int frames_model = 0;
  logic [DW-1:0] pix_vals [NP];

  typedef struct {
    logic [DW-1:0] pix [NP];
    logic [DW-1:0] exp [NP];
    int            mode;
    bit            pulse;
  } vec_t;
  vec_t tbl [4];

  always #5 clk = ~clk;

  // Sensor array model: the selected pixel drives the bus, otherwise junk.
  always_comb begin
    pix_bus = 8'h5A;
    for (int i = 0; i < NP; i++) begin
      if (read_en[i]) pix_bus = pix_vals[i];
    end
  end

  pixel_frame_ctrl dut (
    .clk(clk), .reset(reset), .start(start),
`ifdef PIXEL_TEST_PATTERN_EN
    .test_mode(test_mode),
`endif
    .busy(busy), .erase(erase), .expose(expose), .convert(convert),
    .ramp_cnt(ramp_cnt), .bus_oe(bus_oe), .read_en(read_en), .pix_bus(pix_bus),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .frame_done(frame_done)
  );

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_cyc(input string nm, input logic b, input logic e, input logic x,
                            input logic c, input logic [DW-1:0] r, input logic oe,
                            input logic [NP-1:0] ren, input logic v, input logic fd,
                            input logic [DW-1:0] d, input logic l);
    logic [DW+NP+7:0] act, exp;
    act = {busy, erase, expose, convert, ramp_cnt, bus_oe, read_en, out_valid, frame_done};
    exp = {b, e, x, c, r, oe, ren, v, fd};
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: {busy,erase,expose,convert,ramp,oe,read_en,valid,done} got %h expected %h",
               nm, $time, act, exp);
    end
    if (v) begin
      n_cmp++;
      if ({out_data, out_last} !== {d, l}) begin
        n_err++;
        $display("FAIL %s_data @%0t: data/last got %h/%b expected %h/%b", nm, $time,
                 out_data, out_last, d, l);
      end
    end
  endtask

  task automatic expect_idle(input string nm);
    expect_cyc(nm, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  // mode 0: ready always high, 1: random ready, 2: ready low for 20 cycles on the first word.
  task automatic run_frame(input string nm, input logic [DW-1:0] exp_w [NP], input int mode,
                           input bit pulse);
    logic [NP-1:0] ren;
    bit hs;
    int stalls;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < CE; k++) begin
      expect_cyc({nm, "/erase"}, 1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b1, '0, 1'b0, 1'b0, '0, 1'b0);
      tick();
    end
    for (int k = 0; k < CX; k++) begin
      if (pulse && k == 10) start = 1'b1;
      expect_cyc({nm, "/expose"}, 1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b1, '0, 1'b0, 1'b0, '0, 1'b0);
      tick();
      start = 1'b0;
    end
    for (int k = 0; k < CC; k++) begin
      expect_cyc({nm, "/convert"}, 1'b1, 1'b0, 1'b0, 1'b1, DW'((k > 255) ? 255 : k), 1'b1, '0,
                 1'b0, 1'b0, '0, 1'b0);
      tick();
    end
    for (int p = 0; p < NP; p++) begin
      ren = '0;
      ren[p] = 1'b1;
      expect_cyc({nm, "/rd_sel"}, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, ren, 1'b0, 1'b0, '0, 1'b0);
      tick();
      expect_cyc({nm, "/rd_cap"}, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, ren, 1'b0, 1'b0, '0, 1'b0);
      tick();
      hs = 1'b0;
      stalls = 0;
      while (!hs) begin
        case (mode)
          1:       out_ready = ($urandom_range(0, 2) != 0) || (stalls >= 30);
          2:       out_ready = !(p == 0 && stalls < 20);
          default: out_ready = 1'b1;
        endcase
        expect_cyc({nm, "/rd_wait"}, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1, '0, 1'b1, 1'b0,
                   exp_w[p], (p == NP - 1));
        hs = out_ready;
        stalls++;
        tick();
      end
    end
    out_ready = 1'b1;
    if (pulse) start = 1'b1;
    expect_cyc({nm, "/done"}, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1, '0, 1'b0, 1'b1, '0, 1'b0);
    tick();
    start = 1'b0;
    frames_model++;
    expect_idle({nm, "/idle"});
    tick();
    expect_idle({nm, "/idle2"});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] ew [NP];
    tbl[0].pix = '{8'h10, 8'h80, 8'hFF, 8'h00}; tbl[0].exp = '{8'h10, 8'h80, 8'hFF, 8'h00};
    tbl[0].mode = 0; tbl[0].pulse = 1'b0;
    tbl[1].pix = '{8'h10, 8'h80, 8'hFF, 8'h00}; tbl[1].exp = '{8'h10, 8'h80, 8'hFF, 8'h00};
    tbl[1].mode = 2; tbl[1].pulse = 1'b0;
    tbl[2].pix = '{8'h01, 8'h23, 8'h45, 8'h67}; tbl[2].exp = '{8'h01, 8'h23, 8'h45, 8'h67};
    tbl[2].mode = 0; tbl[2].pulse = 1'b1;
    tbl[3].pix = '{8'hAA, 8'h55, 8'h0F, 8'hF0}; tbl[3].exp = '{8'hAA, 8'h55, 8'h0F, 8'hF0};
    tbl[3].mode = 1; tbl[3].pulse = 1'b0;

    reset = 1'b1;
    start = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < NP; i++) pix_vals[i] = '0;
`ifdef PIXEL_TEST_PATTERN_EN
    test_mode = 1'b0;
`endif
    tick();
    tick();
    reset = 1'b0;
    start = 1'b0;
    tick();
    expect_idle("reset_idle");
    n_cmp++;
    if ({out_data, out_last} !== {DW'(0), 1'b0}) begin
      n_err++;
      $display("FAIL reset_data: got %h/%b expected 00/0", out_data, out_last);
    end

    for (int i = 0; i < 4; i++) begin
      pix_vals = tbl[i].pix;
      run_frame($sformatf("tbl%0d", i), tbl[i].exp, tbl[i].mode, tbl[i].pulse);
    end

    for (int r = 0; r < 3; r++) begin
      for (int p = 0; p < NP; p++) begin
        pix_vals[p] = DW'($urandom);
        ew[p] = pix_vals[p];
      end
      run_frame($sformatf("rand%0d", r), ew, int'($urandom_range(0, 1)), 1'b0);
    end

    // Reset in the middle of CONVERT must clear everything at once.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (CE + CX + 100) tick();
    expect_cyc("pre_reset", 1'b1, 1'b0, 1'b0, 1'b1, 8'd100, 1'b1, '0, 1'b0, 1'b0, '0, 1'b0);
    reset = 1'b1;
    #1;
    expect_idle("mid_reset");
    n_cmp++;
    if ({out_data, out_last} !== {DW'(0), 1'b0}) begin
      n_err++;
      $display("FAIL mid_reset_data: got %h/%b expected 00/0", out_data, out_last);
    end
    @(negedge clk);
    reset = 1'b0;
    frames_model = 0;
    tick();
    pix_vals = '{8'h3C, 8'hC3, 8'h7E, 8'h81};
    ew = '{8'h3C, 8'hC3, 8'h7E, 8'h81};
    run_frame("post_reset", ew, 0, 1'b0);

`ifdef PIXEL_TEST_PATTERN_EN
    reset = 1'b1;
    tick();
    reset = 1'b0;
    frames_model = 0;
    tick();
    test_mode = 1'b1;
    for (int f = 0; f < 2; f++) begin
      for (int p = 0; p < NP; p++) begin
        pix_vals[p] = DW'($urandom);
        ew[p] = DW'(frames_model + p);
      end
      run_frame($sformatf("tpat%0d", f), ew, 0, 1'b0);
    end
    test_mode = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
